// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between the IF stage and instruction memory.
//   imem_req_o   : fetch request, held until imem_ready_i
//   imem_addr_o  : word-aligned fetch address, stable while the request is pending
//   imem_ready_i : memory returns imem_data_i this cycle and completes the request
//   imem_data_i  : fetched instruction word
// master = IF stage side, slave = memory side.
interface if_stage_if;
    localparam int unsigned XLEN = 32;

    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_ready_i;
    logic [XLEN-1:0] imem_data_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ready_i,
        input  imem_data_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ready_i,
        output imem_data_i
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: issues fetches, holds the IF/ID pipeline register,
// absorbs one early-returning instruction in a skid register while decode
// stalls, and drops in-flight fetches on redirect.
//   clk_i          : clock, rising edge
//   rst_i          : synchronous active-high reset
//   imem           : instruction-memory bus (master side)
//   stall_i        : decode cannot accept; IF/ID holds
//   redirect_i     : flush / taken branch, overrides stall_i
//   redirect_pc_i  : new fetch address (low two bits ignored)
//   valid_o        : IF/ID holds a live instruction
//   pc_o, instr_o  : IF/ID contents (instr_o = NOP when not valid)
//   opcode_o       : instr_o[6:0]
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    if_stage_if.master  imem,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic [6:0]  opcode_o
);
    localparam int unsigned    XLEN       = 32;
    localparam logic [XLEN-1:0] NOP        = 32'h0000_0013;
    localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [XLEN-1:0] PC_STEP    = 32'd4;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        FETCH   = 2'd1,
        FULL    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t          state_q, state_n;
    logic [XLEN-1:0] pc_q, pc_n;           // next address to fetch (redirect target in DISCARD)
    logic [XLEN-1:0] addr_q, addr_n;       // address presented on the bus
    logic            req_q, req_n;
    logic            valid_q, valid_n;
    logic [XLEN-1:0] pc_out_q, pc_out_n;
    logic [XLEN-1:0] instr_q, instr_n;
    logic [XLEN-1:0] skid_pc_q, skid_pc_n;
    logic [XLEN-1:0] skid_instr_q, skid_instr_n;

    logic            slot_open;
    logic [XLEN-1:0] target_pc;

    assign slot_open = !valid_q || !stall_i;
    assign target_pc = redirect_pc_i & ALIGN_MASK;

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC & ALIGN_MASK;
            addr_q       <= RESET_PC & ALIGN_MASK;
            req_q        <= 1'b0;
            valid_q      <= 1'b0;
            pc_out_q     <= '0;
            instr_q      <= NOP;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP;
        end else begin
            state_q      <= state_n;
            pc_q         <= pc_n;
            addr_q       <= addr_n;
            req_q        <= req_n;
            valid_q      <= valid_n;
            pc_out_q     <= pc_out_n;
            instr_q      <= instr_n;
            skid_pc_q    <= skid_pc_n;
            skid_instr_q <= skid_instr_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n      = state_q;
        pc_n         = pc_q;
        valid_n      = valid_q;
        pc_out_n     = pc_out_q;
        instr_n      = instr_q;
        skid_pc_n    = skid_pc_q;
        skid_instr_n = skid_instr_q;
        addr_n       = addr_q;
        req_n        = 1'b0;

        // Decode takes the current instruction; IF/ID empties unless refilled below
        if (valid_q && !stall_i) begin
            valid_n = 1'b0;
            instr_n = NOP;
        end

        if (redirect_i) begin
            valid_n = 1'b0;
            instr_n = NOP;
            pc_n    = target_pc;
            // Only an un-returned request in flight forces a discard phase
            if ((state_q == FETCH || state_q == DISCARD) && !imem.imem_ready_i) begin
                state_n = DISCARD;
            end else begin
                state_n = FETCH;
            end
        end else begin
            unique case (state_q)
                BOOT: begin
                    state_n = FETCH;
                end
                FETCH: begin
                    if (imem.imem_ready_i) begin
                        pc_n = pc_q + PC_STEP;
                        if (slot_open) begin
                            valid_n  = 1'b1;
                            pc_out_n = pc_q;
                            instr_n  = imem.imem_data_i;
                        end else begin
                            skid_pc_n    = pc_q;
                            skid_instr_n = imem.imem_data_i;
                            state_n      = FULL;
                        end
                    end
                end
                FULL: begin
                    if (!stall_i) begin
                        valid_n  = 1'b1;
                        pc_out_n = skid_pc_q;
                        instr_n  = skid_instr_q;
                        state_n  = FETCH;
                    end
                end
                DISCARD: begin
                    if (imem.imem_ready_i) begin
                        state_n = FETCH;
                    end
                end
                default: begin
                    state_n = BOOT;
                end
            endcase
        end

        // Bus outputs follow the next state; DISCARD keeps the stale address on the bus
        req_n = (state_n == FETCH) || (state_n == DISCARD);
        if (state_n != DISCARD) begin
            addr_n = pc_n;
        end
    end

    assign imem.imem_req_o  = req_q;
    assign imem.imem_addr_o = addr_q;
    assign valid_o          = valid_q;
    assign pc_o             = pc_out_q;
    assign instr_o          = instr_q;
    assign opcode_o         = instr_q[6:0];

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic [6:0]  opcode_o;

    if_stage_if imem_bus ();

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem          (imem_bus),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .valid_o       (valid_o),
        .pc_o          (pc_o),
        .instr_o       (instr_o),
        .opcode_o      (opcode_o)
    );

    int          checks;
    int          errors;
    int          wait_states;
    int          wcnt;
    logic [31:0] xorv;
    logic [63:0] sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    // One clock: memory model answers the current request, scoreboard retires
    // any instruction decode takes at this edge, then advance past the edge.
    task automatic cycle();
        logic [63:0] exp;
        if (imem_bus.imem_req_o === 1'b1) begin
            if (wcnt >= wait_states) begin
                imem_bus.imem_ready_i = 1'b1;
                imem_bus.imem_data_i  = imem_bus.imem_addr_o ^ xorv;
                wcnt = 0;
            end else begin
                imem_bus.imem_ready_i = 1'b0;
                imem_bus.imem_data_i  = 32'hDEAD_BEEF;
                wcnt++;
            end
        end else begin
            imem_bus.imem_ready_i = 1'b0;
            imem_bus.imem_data_i  = 32'hDEAD_BEEF;
            wcnt = 0;
        end
        if (rst) wcnt = 0;
        if (!rst && valid_o === 1'b1 && !stall) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_empty: pc_o=%h instr_o=%h retired, required none", pc_o, instr_o);
            end else begin
                exp = sb.pop_front();
                if ({pc_o, instr_o} !== exp) begin
                    errors++;
                    $display("FAIL sb_order: pc_o/instr_o=%h/%h, required %h/%h",
                             pc_o, instr_o, exp[63:32], exp[31:0]);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc);
        sb.push_back({pc, pc ^ xorv});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        sb.delete();
        cycle();
        rst = 1'b0;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            cycle();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d entries left after %0d cycles, required 0", sb.size(), bound);
        end
        stall = 1'b1;
    endtask

    task automatic test_reset();
        wait_states = 0;
        xorv = '0;
        do_reset();
        checks++;
        if ({valid_o, pc_o, instr_o, imem_bus.imem_req_o} !== {1'b0, 32'h0, NOP, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: valid=%b pc=%h instr=%h req=%b, required 0/0/00000013/0",
                     valid_o, pc_o, instr_o, imem_bus.imem_req_o);
        end
        cycle();
        checks++;
        if (imem_bus.imem_req_o !== 1'b1 || imem_bus.imem_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL boot_exit: req=%b addr=%h, required 1/00000000",
                     imem_bus.imem_req_o, imem_bus.imem_addr_o);
        end
    endtask

    task automatic test_zero_wait();
        wait_states = 0;
        xorv = '0;
        do_reset();
        for (int i = 0; i < 4; i++) push(32'(4 * i));
        cycle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (valid_o !== 1'b1 || pc_o !== 32'(4 * i) || instr_o !== 32'(4 * i)
                || opcode_o !== 7'(4 * i)) begin
                errors++;
                $display("FAIL zero_wait[%0d]: valid=%b pc=%h instr=%h op=%h, required 1/%h/%h",
                         i, valid_o, pc_o, instr_o, opcode_o, 32'(4 * i), 32'(4 * i));
            end
        end
        drain(4);
    endtask

    task automatic test_wait_states();
        wait_states = 2;
        xorv = 32'hCAFE_0000;
        do_reset();
        for (int i = 0; i < 3; i++) push(32'(4 * i));
        cycle();
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 2; j++) begin
                cycle();
                checks++;
                if (valid_o !== 1'b0 || instr_o !== NOP || imem_bus.imem_addr_o !== 32'(4 * k)) begin
                    errors++;
                    $display("FAIL wait_hold[%0d.%0d]: valid=%b instr=%h addr=%h, required 0/00000013/%h",
                             k, j, valid_o, instr_o, imem_bus.imem_addr_o, 32'(4 * k));
                end
            end
            cycle();
            checks++;
            if (valid_o !== 1'b1 || pc_o !== 32'(4 * k) || imem_bus.imem_addr_o !== 32'(4 * k + 4)) begin
                errors++;
                $display("FAIL wait_deliver[%0d]: valid=%b pc=%h addr=%h, required 1/%h/%h",
                         k, valid_o, pc_o, imem_bus.imem_addr_o, 32'(4 * k), 32'(4 * k + 4));
            end
        end
        drain(2);
    endtask

    task automatic test_stall();
        wait_states = 0;
        xorv = 32'h5A00_0000;
        do_reset();
        for (int i = 0; i < 4; i++) push(32'(4 * i));
        cycle();
        cycle();
        cycle();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (valid_o !== 1'b1 || pc_o !== 32'h4 || instr_o !== (32'h4 ^ xorv)
                || imem_bus.imem_req_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b pc=%h instr=%h req=%b, required 1/00000004/%h/0",
                         i, valid_o, pc_o, instr_o, imem_bus.imem_req_o, 32'h4 ^ xorv);
            end
        end
        stall = 1'b0;
        cycle();
        checks++;
        if (pc_o !== 32'h8 || instr_o !== (32'h8 ^ xorv) || valid_o !== 1'b1
            || imem_bus.imem_req_o !== 1'b1 || imem_bus.imem_addr_o !== 32'hC) begin
            errors++;
            $display("FAIL stall_release: pc=%h instr=%h valid=%b req=%b addr=%h, required 00000008/%h/1/1/0000000c",
                     pc_o, instr_o, valid_o, imem_bus.imem_req_o, imem_bus.imem_addr_o, 32'h8 ^ xorv);
        end
        drain(4);
    endtask

    task automatic test_redirect_pending();
        wait_states = 2;
        xorv = 32'h1234_0000;
        do_reset();
        redirect = 1'b1;
        redirect_pc = 32'h10;
        cycle();
        redirect = 1'b1;
        redirect_pc = 32'h100;
        cycle();
        redirect = 1'b0;
        checks++;
        if (imem_bus.imem_req_o !== 1'b1 || imem_bus.imem_addr_o !== 32'h10 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL discard_hold: req=%b addr=%h valid=%b, required 1/00000010/0",
                     imem_bus.imem_req_o, imem_bus.imem_addr_o, valid_o);
        end
        cycle();
        cycle();
        checks++;
        if (valid_o !== 1'b0 || imem_bus.imem_addr_o !== 32'h100) begin
            errors++;
            $display("FAIL discard_drop: valid=%b addr=%h, required 0/00000100", valid_o, imem_bus.imem_addr_o);
        end
        push(32'h100);
        cycle();
        cycle();
        cycle();
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h100 || instr_o !== (32'h100 ^ xorv)) begin
            errors++;
            $display("FAIL redirect_target: valid=%b pc=%h instr=%h, required 1/00000100/%h",
                     valid_o, pc_o, instr_o, 32'h100 ^ xorv);
        end
        drain(2);
    endtask

    task automatic test_redirect_stall();
        wait_states = 0;
        xorv = 32'h0F0F_0000;
        do_reset();
        cycle();
        cycle();
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h103;
        cycle();
        checks++;
        if (valid_o !== 1'b0 || instr_o !== NOP || imem_bus.imem_addr_o !== 32'h100
            || imem_bus.imem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL redirect_stall: valid=%b instr=%h addr=%h req=%b, required 0/00000013/00000100/1",
                     valid_o, instr_o, imem_bus.imem_addr_o, imem_bus.imem_req_o);
        end
        stall = 1'b0;
        redirect = 1'b0;
        push(32'h100);
        cycle();
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h100) begin
            errors++;
            $display("FAIL redirect_align: valid=%b pc=%h, required 1/00000100", valid_o, pc_o);
        end
        drain(2);
    endtask

    task automatic test_wrap();
        wait_states = 0;
        xorv = 32'h7700_0000;
        do_reset();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect = 1'b0;
        push(32'hFFFF_FFFC);
        push(32'h0);
        push(32'h4);
        cycle();
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'hFFFF_FFFC || imem_bus.imem_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL pc_wrap: valid=%b pc=%h addr=%h, required 1/fffffffc/00000000",
                     valid_o, pc_o, imem_bus.imem_addr_o);
        end
        drain(4);
    endtask

    task automatic test_reset_discard();
        wait_states = 1;
        xorv = 32'h4400_0000;
        do_reset();
        cycle();
        redirect = 1'b1;
        redirect_pc = 32'h40;
        cycle();
        redirect = 1'b0;
        checks++;
        if (imem_bus.imem_req_o !== 1'b1 || imem_bus.imem_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL rd_discard: req=%b addr=%h, required 1/00000000",
                     imem_bus.imem_req_o, imem_bus.imem_addr_o);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if ({valid_o, pc_o, instr_o, imem_bus.imem_req_o} !== {1'b0, 32'h0, NOP, 1'b0}) begin
            errors++;
            $display("FAIL rd_reset: valid=%b pc=%h instr=%h req=%b, required 0/0/00000013/0",
                     valid_o, pc_o, instr_o, imem_bus.imem_req_o);
        end
        cycle();
        checks++;
        if (imem_bus.imem_req_o !== 1'b1 || imem_bus.imem_addr_o !== 32'h0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rd_refetch: req=%b addr=%h valid=%b, required 1/00000000/0",
                     imem_bus.imem_req_o, imem_bus.imem_addr_o, valid_o);
        end
        push(32'h0);
        cycle();
        cycle();
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h0) begin
            errors++;
            $display("FAIL rd_first: valid=%b pc=%h, required 1/00000000", valid_o, pc_o);
        end
        drain(2);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        wcnt = 0;
        wait_states = 0;
        xorv = '0;
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        imem_bus.imem_ready_i = 1'b0;
        imem_bus.imem_data_i = '0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_redirect_pending();
        test_redirect_stall();
        test_wrap();
        test_reset_discard();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk_i  in  1  single clock; all state changes on rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 imem_req_o  out  1  fetch request to instruction memory.
REQ-005 imem_addr_o  out  32  fetch address, word-aligned.
REQ-006 imem_ready_i  in  1  memory returns imem_data_i this cycle; completes the request.
REQ-007 imem_data_i  in  32  fetched instruction word.
REQ-008 stall_i  in  1  decode stage cannot accept; hold IF/ID output.
REQ-009 redirect_i  in  1  taken branch / flush from later stage.
REQ-010 redirect_pc_i  in  32  new fetch address when redirect_i=1.
REQ-011 valid_o  out  1  IF/ID register holds a live instruction.
REQ-012 pc_o  out  32  PC of instruction in IF/ID register.
REQ-013 instr_o  out  32  instruction in IF/ID register; 32'h0000_0013 (NOP) when valid_o=0.
REQ-014 opcode_o  out  7  instr_o[6:0], feeds Control Opcode_i.

Function
REQ-015 FSM states: BOOT, FETCH, FULL, DISCARD; registered, one transition per cycle max.
REQ-016 BOOT: imem_req_o=0; next cycle -> FETCH.
REQ-017 FETCH: imem_req_o=1, imem_addr_o=pc; address held stable until imem_ready_i.
REQ-018 Output slot "open" when valid_o=0 or stall_i=0.
REQ-019 FETCH, ready, slot open: IF/ID <= {pc, imem_data_i}, valid_o=1, pc+=4, stay FETCH; one instruction per cycle at zero-wait memory.
REQ-020 FETCH, ready, slot closed: data into skid register, pc+=4, -> FULL.
REQ-021 FETCH, no ready, slot open: valid_o cleared if consumed (valid_o=1, stall_i=0).
REQ-022 FULL: imem_req_o=0; when stall_i=0: IF/ID <= skid, skid empty, -> FETCH.
REQ-023 stall_i=1 with valid_o=1: pc_o, instr_o, valid_o unchanged.
REQ-024 redirect_i overrides stall_i: valid_o<=0, skid emptied, pc <= {redirect_pc_i[31:2],2'b00}.
REQ-025 Redirect in FETCH without ready: -> DISCARD (request in flight).
REQ-026 Redirect in FETCH with ready same cycle: returned data dropped, stay FETCH at new pc.
REQ-027 DISCARD: imem_req_o=1, imem_addr_o=old address held; on ready data dropped, -> FETCH at redirected pc.
REQ-028 Redirect in DISCARD: target updated, state unchanged unless ready same cycle (-> FETCH).
REQ-029 Redirect in FULL or BOOT: -> FETCH at new pc.
REQ-030 pc arithmetic 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
REQ-031 Latency: instruction visible on outputs the cycle after its imem_ready_i.

Reset
REQ-032 rst_i=1 at edge: state=BOOT, pc=RESET_PC, valid_o=0, instr_o=NOP, pc_o=0, skid empty, imem_req_o=0 next cycle; overrides all other inputs.
REQ-033 Reset mid-request (FETCH/DISCARD): request abandoned; memory shares rst_i and drops it; imem_ready_i ignored while rst_i=1.

Verification
REQ-034 Reset, zero-wait memory returning addr as data -> BOOT 1 cycle, then pc_o=0,4,8 on consecutive cycles, valid_o=1, instr_o=pc_o.
REQ-035 2-wait-state memory -> imem_addr_o stable 3 cycles, one instruction per 3 cycles, valid_o low between.
REQ-036 stall_i=1 for 3 cycles with ready at pc=8 -> outputs hold pc=4, FULL with skid=8, imem_req_o=0; stall release -> pc_o=8 next cycle, fetch resumes at 12.
REQ-037 redirect_i to 32'h0000_0100 while request at 0x10 pending, ready 2 cycles later -> valid_o=0, 0x10 data dropped, next instr pc_o=0x100.
REQ-038 redirect_i and stall_i both high with valid_o=1 -> valid_o=0, instr_o=NOP next cycle; redirect_pc_i=0x103 -> fetch 0x100.
REQ-039 rst_i during DISCARD with ready same cycle -> BOOT, pc=RESET_PC, no instruction emitted.
